// File: rtl/lvs_stream_arbiter_pkg.sv
// Shared definitions for the lvs stream arbiter and its helpers.
// State encodings, leaf/length widths and the source-index width rule.
package lvs_stream_arbiter_pkg;

   localparam int LEAF_W = 256;
   localparam int LEN_W  = 8;

   typedef enum logic {
      LVS_ARB_IDLE = 1'b0,
      LVS_ARB_LOCK = 1'b1
   } lvs_arb_state_e;

   // A single producer still needs a one-bit index
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lvs_stream_arbiter_if.sv
// Bundle of the N_SRC leaf-producer channels and the merged lvs output.
// The arbiter uses slave; the producers/consumer side uses master.
interface lvs_stream_arbiter_if #(
   parameter int N_SRC     = 4,
   parameter int QID_WIDTH = 8
);
   import lvs_stream_arbiter_pkg::*;

   localparam int SRC_W = src_width(N_SRC);

   logic [N_SRC-1:0]           i_lvs_vld;
   logic [N_SRC-1:0]           o_lvs_rdy;
   logic [N_SRC*LEAF_W-1:0]    i_lvs;
   logic [N_SRC-1:0]           i_field_ena;
   logic [N_SRC-1:0]           i_last;
   logic [N_SRC*LEN_W-1:0]     i_length;
   logic [N_SRC*QID_WIDTH-1:0] i_qid;

   logic                       o_lvs_vld;
   logic                       i_lvs_rdy;
   logic [LEAF_W-1:0]          o_lvs;
   logic                       o_field_ena;
   logic                       o_last;
   logic [LEN_W-1:0]           o_length;
   logic [QID_WIDTH-1:0]       o_qid;
   logic [SRC_W-1:0]           o_src;
   logic                       o_busy;

   modport slave (
      input  i_lvs_vld, i_lvs, i_field_ena, i_last,
      input  i_length, i_qid, i_lvs_rdy,
      output o_lvs_rdy, o_lvs_vld, o_lvs, o_field_ena,
      output o_last, o_length, o_qid, o_src, o_busy
   );

   modport master (
      output i_lvs_vld, i_lvs, i_field_ena, i_last,
      output i_length, i_qid, i_lvs_rdy,
      input  o_lvs_rdy, o_lvs_vld, o_lvs, o_field_ena,
      input  o_last, o_length, o_qid, o_src, o_busy
   );

endinterface

// File: rtl/lvs_stream_arbiter_rr_pick.sv
// Round-robin first-one finder: first set req bit at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         any
);

   int          pos;
   logic [W-1:0] cand;

   // Scan farthest-to-nearest so the nearest request wins last
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      pos  = 0;
      cand = '0;
      for (int i = N - 1; i >= 0; i--) begin
         pos  = (int'(ptr) + i) % N;
         cand = W'(pos);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lvs_stream_arbiter.sv
// Packet-atomic round-robin merge of N_SRC leaf streams onto one
// registered lvs output; grant is held until the last beat is taken.
module lvs_stream_arbiter
   import lvs_stream_arbiter_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int QID_WIDTH = 8,
   parameter int SRC_W     = src_width(N_SRC)
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   lvs_stream_arbiter_if.slave bus
);

   lvs_arb_state_e   state, state_d;
   logic [SRC_W-1:0] grant, grant_d;
   logic [SRC_W-1:0] ptr, ptr_d;
   logic [SRC_W-1:0] pick_idx;
   logic             pick_any;
   logic             out_free;
   logic             accept;
   logic             last_g;

   rr_pick #(
      .N (N_SRC),
      .W (SRC_W)
   ) u_pick (
      .req (bus.i_lvs_vld),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign out_free   = ~bus.o_lvs_vld | bus.i_lvs_rdy;
   assign last_g     = bus.i_last[grant];
   assign accept     = (state == LVS_ARB_LOCK)
                     & bus.i_lvs_vld[grant] & out_free;
   assign bus.o_busy = (state == LVS_ARB_LOCK);

   // Only the locked source sees ready, and only if the slot can take a beat
   always_comb begin
      bus.o_lvs_rdy = '0;
      if (state == LVS_ARB_LOCK)
         bus.o_lvs_rdy[grant] = out_free;
   end

   // Arbitrate while idle; release the lock once a last beat is taken
   always_comb begin
      state_d = state;
      grant_d = grant;
      ptr_d   = ptr;
      unique case (state)
         LVS_ARB_IDLE: begin
            if (pick_any) begin
               state_d = LVS_ARB_LOCK;
               grant_d = pick_idx;
            end
         end
         LVS_ARB_LOCK: begin
            if (accept && last_g) begin
               state_d = LVS_ARB_IDLE;
               ptr_d   = (grant == SRC_W'(N_SRC - 1))
                       ? '0 : grant + 1'b1;
            end
         end
      endcase
   end

   // State, grant and rotation pointer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= LVS_ARB_IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_d;
         grant <= grant_d;
         ptr   <= ptr_d;
      end
   end

   // Output slot: load on accept, otherwise drain when downstream takes it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_lvs_vld   <= 1'b0;
         bus.o_lvs       <= '0;
         bus.o_field_ena <= 1'b0;
         bus.o_last      <= 1'b0;
         bus.o_length    <= '0;
         bus.o_qid       <= '0;
         bus.o_src       <= '0;
      end else if (accept) begin
         bus.o_lvs_vld   <= 1'b1;
         bus.o_lvs       <= bus.i_lvs[int'(grant)*LEAF_W +: LEAF_W];
         bus.o_field_ena <= bus.i_field_ena[grant];
         bus.o_last      <= last_g;
         bus.o_length    <= bus.i_length[int'(grant)*LEN_W +: LEN_W];
         bus.o_qid       <= bus.i_qid[int'(grant)*QID_WIDTH +: QID_WIDTH];
         bus.o_src       <= grant;
      end else if (bus.i_lvs_rdy) begin
         bus.o_lvs_vld   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lvs_stream_arbiter.sv
// Self-checking bench for lvs_stream_arbiter: cycle table, directed
// corner sequences and randomized packets against a rotation model.
module tb_lvs_stream_arbiter;
   import lvs_stream_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int QW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lvs_stream_arbiter_if #(.N_SRC(N), .QID_WIDTH(QW)) bus ();

   lvs_stream_arbiter #(
      .N_SRC     (N),
      .QID_WIDTH (QW),
      .SRC_W     (2)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [255:0] data;
      logic         fe;
      logic         last;
      logic [7:0]   len;
      logic [7:0]   qid;
      logic [1:0]   src;
   } beat_t;

   typedef struct packed {
      logic [3:0] vld;
      logic [3:0] last;
      logic [7:0] dat;
      logic [7:0] len;
      logic       drdy;
      logic       ev;
      logic [3:0] erdy;
      logic [1:0] esrc;
      logic       el;
      logic [7:0] edat;
      logic [7:0] elen;
      logic       eb;
   } vec_t;

   beat_t src_q [N][$];
   beat_t out_q [$];
   beat_t exp_q [$];
   bit    ovld_h [$];
   int    start_c [N];
   int    dlo [N];
   int    dhi [N];
   int    stall_lo, stall_hi, nhold;
   bit    rnd_rdy;
   int    n_run = 0;
   int    n_fail = 0;

   task automatic chk(input string nm, input logic [299:0] got,
                      input logic [299:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic drive_src(input int cyc);
      beat_t b;
      bit    v;
      for (int s = 0; s < N; s++) begin
         v = src_q[s].size() > 0 && cyc >= start_c[s]
             && !(cyc >= dlo[s] && cyc < dhi[s]);
         b = '0;
         if (src_q[s].size() > 0) b = src_q[s][0];
         bus.i_lvs_vld[s]          = v;
         bus.i_lvs[s*256 +: 256]   = b.data;
         bus.i_field_ena[s]        = b.fe;
         bus.i_last[s]             = b.last;
         bus.i_length[s*8 +: 8]    = b.len;
         bus.i_qid[s*QW +: QW]     = b.qid;
      end
   endtask

   task automatic clear_all();
      for (int s = 0; s < N; s++) begin
         src_q[s].delete();
         start_c[s] = 0;
         dlo[s] = 0;
         dhi[s] = 0;
      end
      out_q.delete();
      exp_q.delete();
      ovld_h.delete();
      stall_lo = 0;
      stall_hi = 0;
      nhold = 0;
      rnd_rdy = 0;
   endtask

   task automatic do_reset();
      clear_all();
      rst_n = 1'b0;
      drive_src(0);
      bus.i_lvs_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic add_pkt(input int s, input int nb,
                          input logic [255:0] base);
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         b.data = base + 256'(i);
         b.fe   = 1'(i & 1);
         b.last = (i == nb - 1);
         b.len  = 8'(nb * 16 + i);
         b.qid  = 8'(s * 32 + i);
         b.src  = 2'(s);
         src_q[s].push_back(b);
      end
   endtask

   // Expected order: whole packets, rotating from the pointer, which
   // restarts at 0 and moves past each served source
   task automatic rr_model();
      beat_t q [N][$];
      beat_t b;
      int    p, s;
      bit    found;
      for (int k = 0; k < N; k++) q[k] = src_q[k];
      exp_q.delete();
      p = 0;
      s = 0;
      forever begin
         found = 0;
         for (int k = 0; k < N && !found; k++) begin
            s = (p + k) % N;
            if (q[s].size() > 0) found = 1;
         end
         if (!found) break;
         do begin
            b = q[s].pop_front();
            exp_q.push_back(b);
         end while (!b.last && q[s].size() > 0);
         p = (s + 1) % N;
      end
   endtask

   task automatic run_stream(input int ncyc);
      logic [N-1:0] acc;
      beat_t        cur, prev;
      bit           hold;
      hold = 0;
      prev = '0;
      for (int c = 0; c < ncyc; c++) begin
         drive_src(c);
         bus.i_lvs_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0)
                                 : !(c >= stall_lo && c < stall_hi);
         @(negedge clk);
         cur.data = bus.o_lvs;
         cur.fe   = bus.o_field_ena;
         cur.last = bus.o_last;
         cur.len  = bus.o_length;
         cur.qid  = bus.o_qid;
         cur.src  = bus.o_src;
         if (hold) begin
            chk("hold_beat", cur, prev);
            chk("hold_vld", bus.o_lvs_vld, 1'b1);
         end
         chk("rdy_1hot", 300'($countones(bus.o_lvs_rdy) > 1), 0);
         ovld_h.push_back(bus.o_lvs_vld);
         if (bus.o_lvs_vld && bus.i_lvs_rdy) out_q.push_back(cur);
         hold = bus.o_lvs_vld && !bus.i_lvs_rdy;
         if (hold) begin
            nhold++;
            chk("stall_rdy", bus.o_lvs_rdy, 0);
         end
         prev = cur;
         acc  = bus.i_lvs_vld & bus.o_lvs_rdy;
         @(posedge clk);
         #1;
         for (int s = 0; s < N; s++)
            if (acc[s]) void'(src_q[s].pop_front());
      end
   endtask

   task automatic check_outs(input string nm);
      int n;
      chk({nm, "_count"}, out_q.size(), exp_q.size());
      n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({nm, "_beat"}, out_q[i], exp_q[i]);
   endtask

   function automatic logic [299:0] all_outs();
      return 300'({bus.o_lvs_vld, bus.o_lvs, bus.o_field_ena,
                   bus.o_last, bus.o_length, bus.o_qid, bus.o_src,
                   bus.o_busy, bus.o_lvs_rdy});
   endfunction

   vec_t vt [5];

   initial begin
      beat_t b;
      int    np, nb;

      clear_all();
      rst_n = 1'b0;
      drive_src(0);
      bus.i_lvs_rdy = 1'b0;
      #1;
      chk("reset_vals", all_outs(), 0);

      // Source 2, two-beat packet, downstream always ready
      vt[0] = '{4'h4, 4'h0, 8'hA, 8'd255, 1'b1,
                1'b0, 4'h0, 2'd0, 1'b0, 8'h0, 8'd0, 1'b0};
      vt[1] = '{4'h4, 4'h0, 8'hA, 8'd255, 1'b1,
                1'b0, 4'h4, 2'd0, 1'b0, 8'h0, 8'd0, 1'b1};
      vt[2] = '{4'h4, 4'h4, 8'hB, 8'd248, 1'b1,
                1'b1, 4'h4, 2'd2, 1'b0, 8'hA, 8'd255, 1'b1};
      vt[3] = '{4'h0, 4'h0, 8'h0, 8'd0, 1'b1,
                1'b1, 4'h0, 2'd2, 1'b1, 8'hB, 8'd248, 1'b0};
      vt[4] = '{4'h0, 4'h0, 8'h0, 8'd0, 1'b1,
                1'b0, 4'h0, 2'd0, 1'b0, 8'h0, 8'd0, 1'b0};
      do_reset();
      for (int r = 0; r < 5; r++) begin
         for (int s = 0; s < N; s++) begin
            bus.i_lvs_vld[s]        = vt[r].vld[s];
            bus.i_last[s]           = vt[r].last[s];
            bus.i_lvs[s*256 +: 256] = 256'(vt[r].dat);
            bus.i_length[s*8 +: 8]  = vt[r].len;
            bus.i_qid[s*QW +: QW]   = 8'h5;
            bus.i_field_ena[s]      = 1'b0;
         end
         bus.i_lvs_rdy = vt[r].drdy;
         @(negedge clk);
         chk("t1_vld", bus.o_lvs_vld, vt[r].ev);
         chk("t1_rdy", bus.o_lvs_rdy, vt[r].erdy);
         chk("t1_busy", bus.o_busy, vt[r].eb);
         if (vt[r].ev) begin
            chk("t1_src", bus.o_src, vt[r].esrc);
            chk("t1_last", bus.o_last, vt[r].el);
            chk("t1_data", bus.o_lvs, 256'(vt[r].edat));
            chk("t1_len", bus.o_length, vt[r].elen);
            chk("t1_qid", bus.o_qid, 8'h5);
         end
         @(posedge clk);
         #1;
      end

      // Sources 0,1,3 with back-to-back single-beat packets
      do_reset();
      for (int k = 0; k < 2; k++) begin
         add_pkt(0, 1, 256'h100 + 256'(k));
         add_pkt(1, 1, 256'h200 + 256'(k));
         add_pkt(3, 1, 256'h300 + 256'(k));
      end
      rr_model();
      run_stream(14);
      check_outs("t2");
      for (int c = 0; c < 14; c++)
         chk("t2_bubble", ovld_h[c], (c >= 2 && c <= 12 && c % 2 == 0));

      // Five-cycle downstream stall in the middle of a packet
      do_reset();
      add_pkt(0, 4, 256'h11);
      stall_lo = 3;
      stall_hi = 8;
      rr_model();
      run_stream(16);
      check_outs("t3");
      chk("t3_stalls", nhold, 5);

      // Granted source 1 goes quiet mid-packet while source 0 waits
      do_reset();
      add_pkt(1, 3, 256'h41);
      add_pkt(0, 1, 256'h51);
      start_c[0] = 2;
      dlo[1] = 3;
      dhi[1] = 6;
      foreach (src_q[1][i]) exp_q.push_back(src_q[1][i]);
      exp_q.push_back(src_q[0][0]);
      run_stream(14);
      check_outs("t4");

      // Reset while source 3 holds the lock, pointer previously at 3
      do_reset();
      add_pkt(2, 1, 256'h61);
      add_pkt(3, 4, 256'h71);
      run_stream(5);
      chk("t5_busy", bus.o_busy, 1'b1);
      chk("t5_src", bus.o_src, 2'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async", all_outs(), 0);
      clear_all();
      drive_src(0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      add_pkt(3, 1, 256'h81);
      add_pkt(0, 1, 256'h91);
      rr_model();
      run_stream(10);
      check_outs("t5");
      if (exp_q.size() == 2) begin
         chk("t5_first", exp_q[0].src, 2'd0);
         if (out_q.size() > 0) chk("t5_order", out_q[0].src, 2'd0);
      end

      // Three-beat packet streamed with no gaps in o_lvs_vld
      do_reset();
      add_pkt(1, 3, 256'hA0);
      rr_model();
      run_stream(8);
      check_outs("t6");
      for (int c = 2; c < 6; c++) chk("t6_vld", ovld_h[c], c < 5);

      // Randomized packets and downstream ready
      for (int r = 0; r < 6; r++) begin
         do_reset();
         rnd_rdy = 1;
         for (int s = 0; s < N; s++) begin
            np = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 3) : 0;
            for (int p = 0; p < np; p++) begin
               nb = $urandom_range(1, 4);
               for (int i = 0; i < nb; i++) begin
                  for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom();
                  b.fe   = 1'($urandom_range(0, 1));
                  b.last = (i == nb - 1);
                  b.len  = 8'($urandom_range(0, 255));
                  b.qid  = 8'($urandom_range(0, 255));
                  b.src  = 2'(s);
                  src_q[s].push_back(b);
               end
            end
         end
         rr_model();
         run_stream(300);
         check_outs("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
